// File: rtl/gcd_sequencer_pkg.sv
// Shared definitions for the gcd sequencer slice.
//   GCD_WIDTH      default operand/result width (must match the gcd core)
//   *_IDX          bit position of each state in the one-hot state vector
//   state_t        one-hot FSM encoding built from the *_IDX positions
package gcd_sequencer_pkg;

   localparam int GCD_WIDTH = 8;

   localparam int IDLE_IDX = 0;
   localparam int LOAD_IDX = 1;
   localparam int RUN_IDX  = 2;
   localparam int RESP_IDX = 3;

   typedef enum logic [3:0] {
      ST_IDLE = 4'(1 << IDLE_IDX),
      ST_LOAD = 4'(1 << LOAD_IDX),
      ST_RUN  = 4'(1 << RUN_IDX),
      ST_RESP = 4'(1 << RESP_IDX)
   } state_t;

endpackage

// File: rtl/gcd_sequencer_if.sv
// Bundles the operand channel, the result channel and the gcd core side-band.
//   master : the sequencer (drives in_ready, gcd_start/a/b, out_valid/ret/err)
//   slave  : the environment (operand source, gcd core, result consumer)
interface gcd_sequencer_if
   import gcd_sequencer_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             gcd_start;
   logic [WIDTH-1:0] gcd_a;
   logic [WIDTH-1:0] gcd_b;
   logic [WIDTH-1:0] gcd_ret;
   logic             gcd_done;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_ret;
   logic             out_err;

   modport master (
      input  in_valid, in_a, in_b, gcd_ret, gcd_done, out_ready,
      output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_ret, out_err
   );

   modport slave (
      output in_valid, in_a, in_b, gcd_ret, gcd_done, out_ready,
      input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_ret, out_err
   );
endinterface

// File: rtl/gcd_sequencer_watchdog.sv
// RUN-state watchdog for the gcd sequencer.
//   clk, rst  clock, async active-high reset
//   clear     reload the timer (sequencer in LOAD)
//   run       sequencer in RUN; timer counts down one per cycle
//   expired   high during the TIMEOUT_CYCLES-th RUN cycle
// Only instantiated when GCD_SEQ_TIMEOUT_EN is defined.
module gcd_sequencer_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TC_VAL   = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= LOAD_VAL;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Terminal count is 1, so the edge ending the last allowed RUN cycle
   // is the one that sees expired.
   assign expired = run && (cnt == TC_VAL);

endmodule

// File: rtl/gcd_sequencer.sv
// Front/back-end sequencer for the gcd core.
//   clk, rst  single rising-edge clock, async active-high reset
//   bus       gcd_sequencer_if.master:
//               in_valid/in_ready/in_a/in_b   operand pair channel
//               gcd_start/gcd_a/gcd_b         drive gcd.rst / gcd.a_in / gcd.b_in
//               gcd_ret/gcd_done              from gcd.ret_out / gcd.done_out
//               out_valid/out_ready/out_ret   result channel
//               out_err                       RUN timeout flag
// Optional feature: GCD_SEQ_TIMEOUT_EN enables the RUN watchdog; without it
// RUN waits for gcd_done indefinitely and out_err stays 0.
//
//   state | meaning
//   IDLE  | gcd held in load, accepting an operand pair
//   LOAD  | one cycle with new operands stable while gcd_start is high
//   RUN   | gcd iterating, waiting for gcd_done (or watchdog expiry)
//   RESP  | result presented, waiting for out_ready
module gcd_sequencer
   import gcd_sequencer_pkg::*;
#(
   parameter int WIDTH          = GCD_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   gcd_sequencer_if.master   bus
);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t state;
   logic   wd_expired;

`ifdef GCD_SEQ_TIMEOUT_EN
   gcd_sequencer_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_LOAD),
      .run     (state == ST_RUN),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         bus.in_ready  <= 1'b1;
         bus.gcd_start <= 1'b1;
         bus.gcd_a     <= ZERO;
         bus.gcd_b     <= ZERO;
         bus.out_valid <= 1'b0;
         bus.out_ret   <= ZERO;
         bus.out_err   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  bus.gcd_a    <= bus.in_a;
                  bus.gcd_b    <= bus.in_b;
                  bus.in_ready <= 1'b0;
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               bus.gcd_start <= 1'b0;
               state         <= ST_RUN;
            end
            ST_RUN: begin
               // gcd_done takes priority over a watchdog expiry on the same edge.
               if (bus.gcd_done) begin
                  bus.out_ret   <= bus.gcd_ret;
                  bus.out_err   <= 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= ST_RESP;
               end else if (wd_expired) begin
                  bus.out_ret   <= ZERO;
                  bus.out_err   <= 1'b1;
                  bus.out_valid <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               // gcd_start stays low here so the core parks in its done state.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.gcd_start <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               bus.gcd_start <= 1'b1;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer with a behavioural subtractive gcd core alongside.
module tb_gcd_sequencer;
   import gcd_sequencer_pkg::*;

   localparam int W          = 8;
   localparam int TB_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gcd_sequencer_if #(.WIDTH(W)) bus ();

   gcd_sequencer #(
      .WIDTH          (W),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Subtractive gcd core: synchronous load while gcd_start is high.
   logic [W-1:0] gx, gy;
   always @(posedge clk) begin
      if (rst) begin
         bus.gcd_done <= 1'b0;
         bus.gcd_ret  <= '0;
      end else if (bus.gcd_start) begin
         gx           <= bus.gcd_a;
         gy           <= bus.gcd_b;
         bus.gcd_done <= 1'b0;
         bus.gcd_ret  <= '0;
      end else if (!bus.gcd_done) begin
         if (gy == 0) begin
            bus.gcd_ret <= gx; bus.gcd_done <= 1'b1;
         end else if (gx == 0) begin
            bus.gcd_ret <= gy; bus.gcd_done <= 1'b1;
         end else if (gx == gy) begin
            bus.gcd_ret <= gx; bus.gcd_done <= 1'b1;
         end else if (gx > gy) begin
            gx <= gx - gy;
         end else begin
            gy <= gy - gx;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_hs     = 0;

   typedef struct {
      logic [W-1:0] ret;
      logic         err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         hold;
      logic [W-1:0] exp_ret;
      logic         exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Result monitor: sampled mid-low-phase, handshake completes on next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               fail("unexpected_out_valid");
            end else begin
               e = sb.pop_front();
               check("out_ret", 32'(bus.out_ret), 32'(e.ret));
               check("out_err", 32'(bus.out_err), 32'(e.err));
               n_hs++;
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ret, input logic err);
      exp_t e;
      bit   ok = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      e.ret = ret;
      e.err = err;
      sb.push_back(e);
      for (int i = 0; i < 1000; i++) begin
         #3;
         if (bus.in_ready) begin
            @(negedge clk);
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) fail("send_accept");
   endtask

   // Waits until all expected results are consumed, checking in_ready stays low meanwhile.
   task automatic drain();
      bit done = 0;
      int busy_bad = 0;
      for (int i = 0; i < 2000; i++) begin
         #3;
         if (sb.size() == 0) begin
            done = 1;
            break;
         end
         if (bus.in_ready) busy_bad++;
         @(negedge clk);
      end
      if (!done) fail("drain");
      @(negedge clk);
      check("busy_in_ready_low", 32'(busy_bad), 32'd0);
      #3;
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
   endtask

   vec_t vecs[$];

   initial begin
      int hs0;
      int bad;
      bit seen;

      vecs.push_back('{a: 8'd12,  b: 8'd8,   hold: 1'b0, exp_ret: 8'd4,  exp_err: 1'b0});
      vecs.push_back('{a: 8'd17,  b: 8'd0,   hold: 1'b0, exp_ret: 8'd17, exp_err: 1'b0});
      vecs.push_back('{a: 8'd0,   b: 8'd0,   hold: 1'b0, exp_ret: 8'd0,  exp_err: 1'b0});
      vecs.push_back('{a: 8'd48,  b: 8'd18,  hold: 1'b1, exp_ret: 8'd6,  exp_err: 1'b0});
      vecs.push_back('{a: 8'd255, b: 8'd85,  hold: 1'b1, exp_ret: 8'd85, exp_err: 1'b0});
      vecs.push_back('{a: 8'd7,   b: 8'd13,  hold: 1'b0, exp_ret: 8'd1,  exp_err: 1'b0});
`ifdef GCD_SEQ_TIMEOUT_EN
      vecs.push_back('{a: 8'd255, b: 8'd254, hold: 1'b0, exp_ret: 8'd0,  exp_err: 1'b1});
`else
      vecs.push_back('{a: 8'd255, b: 8'd254, hold: 1'b0, exp_ret: 8'd1,  exp_err: 1'b0});
`endif

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_gcd_start", 32'(bus.gcd_start), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_ret",   32'(bus.out_ret),   32'd0);
      check("rst_out_err",   32'(bus.out_err),   32'd0);
      check("rst_gcd_a",     32'(bus.gcd_a),     32'd0);
      check("rst_gcd_b",     32'(bus.gcd_b),     32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table: single pairs, zero operands, back-to-back, long-running pair.
      hs0 = n_hs;
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].exp_ret, vecs[i].exp_err);
         if (!vecs[i].hold) begin
            bus.in_valid = 1'b0;
            drain();
         end
      end
      check("table_handshakes", 32'(n_hs - hs0), 32'(vecs.size()));

      // Back-pressure: result held for 10 cycles with out_ready low.
      bus.out_ready = 1'b0;
      hs0 = n_hs;
      send(8'd48, 8'd18, 8'd6, 1'b0);
      bus.in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         #3;
         if (bus.out_valid) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) fail("resp_wait");
      @(negedge clk);
      bad = 0;
      repeat (10) begin
         #3;
         if (bus.out_valid !== 1'b1 || bus.out_ret !== 8'd6 || bus.in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      check("resp_hold_stable", 32'(bad), 32'd0);
      bus.out_ready = 1'b1;
      drain();
      check("resp_single_handshake", 32'(n_hs - hs0), 32'd1);

      // Reset in the middle of RUN discards the result.
      hs0 = n_hs;
      send(8'd200, 8'd150, 8'd50, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrun_rst_gcd_start", 32'(bus.gcd_start), 32'd1);
      check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrun_rst_in_ready",  32'(bus.in_ready),  32'd1);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         #3;
         if (bus.out_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      check("midrun_no_out_valid", 32'(bad), 32'd0);
      send(8'd9, 8'd6, 8'd3, 1'b0);
      bus.in_valid = 1'b0;
      drain();
      check("after_rst_handshakes", 32'(n_hs - hs0), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
